// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing constants for the reorder buffer.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_IDX_W  = 4;
  localparam int ROB_PREG_W = 6;
  localparam int ROB_PC_W   = 32;

  // Payload carried by an entry from allocation to commit.
  typedef struct packed {
    logic [ROB_PREG_W-1:0] dest_reg;
    logic [ROB_PREG_W-1:0] old_dest_reg;
    logic [ROB_PC_W-1:0]   pc;
  } rob_row_t;

  // One ROB slot: payload plus liveness and completion flags.
  typedef struct packed {
    logic     v;
    logic     done;
    rob_row_t row;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// 16-entry in-order retire buffer: dual allocate at tail, triple writeback
// by index, dual in-order commit from head.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int PREG_W = ROB_PREG_W,
  parameter int PC_W   = ROB_PC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid_1,
  input  logic                     alloc_valid_2,
  input  logic [PREG_W-1:0]        alloc_pd_1,
  input  logic [PREG_W-1:0]        alloc_pd_2,
  input  logic [PREG_W-1:0]        alloc_old_pd_1,
  input  logic [PREG_W-1:0]        alloc_old_pd_2,
  input  logic [PC_W-1:0]          alloc_pc_1,
  input  logic [PC_W-1:0]          alloc_pc_2,
  output logic                     alloc_ready,
  output logic [$clog2(DEPTH)-1:0] alloc_idx_1,
  output logic [$clog2(DEPTH)-1:0] alloc_idx_2,
  input  logic                     wb_valid_1,
  input  logic                     wb_valid_2,
  input  logic                     wb_valid_3,
  input  logic [$clog2(DEPTH)-1:0] wb_rob_idx_1,
  input  logic [$clog2(DEPTH)-1:0] wb_rob_idx_2,
  input  logic [$clog2(DEPTH)-1:0] wb_rob_idx_3,
  output logic                     commit_valid_1,
  output logic                     commit_valid_2,
  output logic [PREG_W-1:0]        commit_pd_1,
  output logic [PREG_W-1:0]        commit_pd_2,
  output logic [PREG_W-1:0]        commit_old_pd_1,
  output logic [PREG_W-1:0]        commit_old_pd_2,
  output logic [PC_W-1:0]          commit_pc_1,
  output logic [PC_W-1:0]          commit_pc_2,
  output logic [$clog2(DEPTH):0]   rob_count,
  output logic                     rob_empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rob_entry_t       entries_q [DEPTH];
  rob_entry_t       entries_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [IDX_W-1:0] head_nxt;
  logic             acc_1, acc_2;
  logic [1:0]       n_alloc, n_commit;

  // Commit outputs, allocation indices and next-state for the entry array and pointers.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    // Readiness uses the pre-commit count, so a full buffer never overflows.
    alloc_ready = (count_q <= CNT_W'(DEPTH - 2));
    alloc_idx_1 = tail_q;
    alloc_idx_2 = tail_q + IDX_W'(alloc_valid_1);
    acc_1       = alloc_ready & alloc_valid_1;
    acc_2       = alloc_ready & alloc_valid_2;
    n_alloc     = {1'b0, acc_1} + {1'b0, acc_2};

    // Slot 2 only retires behind slot 1; commit reads registered state, no writeback bypass.
    head_nxt       = head_q + IDX_W'(1);
    commit_valid_1 = entries_q[head_q].v & entries_q[head_q].done;
    commit_valid_2 = commit_valid_1 & entries_q[head_nxt].v & entries_q[head_nxt].done;
    n_commit       = {1'b0, commit_valid_1} + {1'b0, commit_valid_2};

    commit_pd_1     = commit_valid_1 ? entries_q[head_q].row.dest_reg       : '0;
    commit_old_pd_1 = commit_valid_1 ? entries_q[head_q].row.old_dest_reg   : '0;
    commit_pc_1     = commit_valid_1 ? entries_q[head_q].row.pc             : '0;
    commit_pd_2     = commit_valid_2 ? entries_q[head_nxt].row.dest_reg     : '0;
    commit_old_pd_2 = commit_valid_2 ? entries_q[head_nxt].row.old_dest_reg : '0;
    commit_pc_2     = commit_valid_2 ? entries_q[head_nxt].row.pc           : '0;

    // Writeback only marks live entries; stray indices are dropped.
    if (wb_valid_1 && entries_q[wb_rob_idx_1].v) entries_d[wb_rob_idx_1].done = 1'b1;
    if (wb_valid_2 && entries_q[wb_rob_idx_2].v) entries_d[wb_rob_idx_2].done = 1'b1;
    if (wb_valid_3 && entries_q[wb_rob_idx_3].v) entries_d[wb_rob_idx_3].done = 1'b1;

    if (commit_valid_1) begin
      entries_d[head_q].v    = 1'b0;
      entries_d[head_q].done = 1'b0;
    end
    if (commit_valid_2) begin
      entries_d[head_nxt].v    = 1'b0;
      entries_d[head_nxt].done = 1'b0;
    end

    // Tail slots are free whenever alloc_ready is high, so they never collide with commit.
    if (acc_1) entries_d[alloc_idx_1] = '{1'b1, 1'b0, '{alloc_pd_1, alloc_old_pd_1, alloc_pc_1}};
    if (acc_2) entries_d[alloc_idx_2] = '{1'b1, 1'b0, '{alloc_pd_2, alloc_old_pd_2, alloc_pc_2}};

    head_d  = head_q + IDX_W'(n_commit);
    tail_d  = tail_q + IDX_W'(n_alloc);
    count_d = count_q + CNT_W'(n_alloc) - CNT_W'(n_commit);
  end

  // All architectural state; reset wins over same-cycle alloc and writeback.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: only the v/done flags are reset; payload fields are don't-care until written.
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].v    <= 1'b0;
        entries_q[i].done <= 1'b0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign rob_count = count_q;
  assign rob_empty = (count_q == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a
// randomized run against a program-order queue model.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid_1, alloc_valid_2;
  logic [5:0]  alloc_pd_1, alloc_pd_2, alloc_old_pd_1, alloc_old_pd_2;
  logic [31:0] alloc_pc_1, alloc_pc_2;
  logic        alloc_ready;
  logic [3:0]  alloc_idx_1, alloc_idx_2;
  logic        wb_valid_1, wb_valid_2, wb_valid_3;
  logic [3:0]  wb_rob_idx_1, wb_rob_idx_2, wb_rob_idx_3;
  logic        commit_valid_1, commit_valid_2;
  logic [5:0]  commit_pd_1, commit_pd_2, commit_old_pd_1, commit_old_pd_2;
  logic [31:0] commit_pc_1, commit_pc_2;
  logic [4:0]  rob_count;
  logic        rob_empty;

  int checks   = 0;
  int failures = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
    .alloc_pd_1(alloc_pd_1), .alloc_pd_2(alloc_pd_2),
    .alloc_old_pd_1(alloc_old_pd_1), .alloc_old_pd_2(alloc_old_pd_2),
    .alloc_pc_1(alloc_pc_1), .alloc_pc_2(alloc_pc_2),
    .alloc_ready(alloc_ready), .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
    .wb_valid_1(wb_valid_1), .wb_valid_2(wb_valid_2), .wb_valid_3(wb_valid_3),
    .wb_rob_idx_1(wb_rob_idx_1), .wb_rob_idx_2(wb_rob_idx_2), .wb_rob_idx_3(wb_rob_idx_3),
    .commit_valid_1(commit_valid_1), .commit_valid_2(commit_valid_2),
    .commit_pd_1(commit_pd_1), .commit_pd_2(commit_pd_2),
    .commit_old_pd_1(commit_old_pd_1), .commit_old_pd_2(commit_old_pd_2),
    .commit_pc_1(commit_pc_1), .commit_pc_2(commit_pc_2),
    .rob_count(rob_count), .rob_empty(rob_empty)
  );

  always #5 clk = ~clk;

  // Reference model: instructions in program order, oldest first.
  typedef struct {
    logic [5:0]  pd;
    logic [5:0]  old;
    logic [31:0] pc;
    bit          done;
    int          idx;
  } ins_t;

  ins_t rob_q[$];
  int   m_tail = 0;

  // Number of instructions the model retires at the coming edge.
  function automatic int exp_n_commit();
    int n = 0;
    if (rob_q.size() >= 1 && rob_q[0].done) n = 1;
    if (n == 1 && rob_q.size() >= 2 && rob_q[1].done) n = 2;
    return n;
  endfunction

  task automatic clear_inputs();
    alloc_valid_1 = 0; alloc_valid_2 = 0;
    alloc_pd_1 = 0; alloc_pd_2 = 0; alloc_old_pd_1 = 0; alloc_old_pd_2 = 0;
    alloc_pc_1 = 0; alloc_pc_2 = 0;
    wb_valid_1 = 0; wb_valid_2 = 0; wb_valid_3 = 0;
    wb_rob_idx_1 = 0; wb_rob_idx_2 = 0; wb_rob_idx_3 = 0;
  endtask

  task automatic set_alloc1(input logic [5:0] pd, input logic [5:0] old, input logic [31:0] pc);
    alloc_valid_1 = 1; alloc_pd_1 = pd; alloc_old_pd_1 = old; alloc_pc_1 = pc;
  endtask

  task automatic set_alloc2(input logic [5:0] pd, input logic [5:0] old, input logic [31:0] pc);
    alloc_valid_2 = 1; alloc_pd_2 = pd; alloc_old_pd_2 = old; alloc_pc_2 = pc;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    int       nc    = exp_n_commit();
    bit       ready = (rob_q.size() <= 14);
    bit       wv[3];
    int       wi[3];
    @(posedge clk);
    wv[0] = wb_valid_1; wv[1] = wb_valid_2; wv[2] = wb_valid_3;
    wi[0] = wb_rob_idx_1; wi[1] = wb_rob_idx_2; wi[2] = wb_rob_idx_3;
    if (rst) begin
      rob_q.delete();
      m_tail = 0;
    end else begin
      repeat (nc) void'(rob_q.pop_front());
      for (int k = 0; k < 3; k++)
        if (wv[k])
          foreach (rob_q[j]) if (rob_q[j].idx == wi[k]) rob_q[j].done = 1;
      if (ready && alloc_valid_1) begin
        rob_q.push_back('{alloc_pd_1, alloc_old_pd_1, alloc_pc_1, 0, m_tail});
        m_tail = (m_tail + 1) % 16;
      end
      if (ready && alloc_valid_2) begin
        rob_q.push_back('{alloc_pd_2, alloc_old_pd_2, alloc_pc_2, 0, m_tail});
        m_tail = (m_tail + 1) % 16;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (rob_empty !== 1'b1)      begin failures++; $display("FAIL reset_empty got=%0d exp=1", rob_empty); end
    checks++; if (rob_count !== 5'd0)      begin failures++; $display("FAIL reset_count got=%0d exp=0", rob_count); end
    checks++; if (alloc_ready !== 1'b1)    begin failures++; $display("FAIL reset_ready got=%0d exp=1", alloc_ready); end
    checks++; if (commit_valid_1 !== 1'b0) begin failures++; $display("FAIL reset_cv1 got=%0d exp=0", commit_valid_1); end
    checks++; if (commit_valid_2 !== 1'b0) begin failures++; $display("FAIL reset_cv2 got=%0d exp=0", commit_valid_2); end
    checks++; if (alloc_idx_1 !== 4'd0)    begin failures++; $display("FAIL reset_idx1 got=%0d exp=0", alloc_idx_1); end
    checks++; if (alloc_idx_2 !== 4'd0)    begin failures++; $display("FAIL reset_idx2 got=%0d exp=0", alloc_idx_2); end
  endtask

  task automatic test_out_of_order_done();
    do_reset();
    set_alloc1(6'd32, 6'd5, 32'd0);
    set_alloc2(6'd33, 6'd6, 32'd4);
    #1;
    checks++; if (alloc_idx_1 !== 4'd0) begin failures++; $display("FAIL ooo_idx1 got=%0d exp=0", alloc_idx_1); end
    checks++; if (alloc_idx_2 !== 4'd1) begin failures++; $display("FAIL ooo_idx2 got=%0d exp=1", alloc_idx_2); end
    tick();
    clear_inputs();
    wb_valid_1 = 1; wb_rob_idx_1 = 4'd1;
    #1;
    checks++; if (rob_count !== 5'd2)      begin failures++; $display("FAIL ooo_count got=%0d exp=2", rob_count); end
    checks++; if (commit_valid_1 !== 1'b0) begin failures++; $display("FAIL ooo_cv_before got=%0d exp=0", commit_valid_1); end
    tick();
    clear_inputs();
    #1;
    checks++; if (commit_valid_1 !== 1'b0) begin failures++; $display("FAIL ooo_cv_young_done got=%0d exp=0", commit_valid_1); end
    wb_valid_2 = 1; wb_rob_idx_2 = 4'd0;
    tick();
    clear_inputs();
    #1;
    checks++; if (commit_valid_1 !== 1'b1 || commit_valid_2 !== 1'b1) begin failures++; $display("FAIL ooo_cv_both got=%0d%0d exp=11", commit_valid_1, commit_valid_2); end
    checks++; if (commit_old_pd_1 !== 6'd5 || commit_old_pd_2 !== 6'd6) begin failures++; $display("FAIL ooo_old_pd got=%0d,%0d exp=5,6", commit_old_pd_1, commit_old_pd_2); end
    checks++; if (commit_pc_1 !== 32'd0 || commit_pc_2 !== 32'd4) begin failures++; $display("FAIL ooo_pc got=%0d,%0d exp=0,4", commit_pc_1, commit_pc_2); end
    checks++; if (commit_pd_1 !== 6'd32 || commit_pd_2 !== 6'd33) begin failures++; $display("FAIL ooo_pd got=%0d,%0d exp=32,33", commit_pd_1, commit_pd_2); end
    tick();
    #1;
    checks++; if (rob_empty !== 1'b1)  begin failures++; $display("FAIL ooo_empty got=%0d exp=1", rob_empty); end
    checks++; if (commit_pc_1 !== 32'd0) begin failures++; $display("FAIL ooo_idle_payload got=%0h exp=0", commit_pc_1); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      set_alloc1(6'(i), 6'(i), 32'(8 * i));
      set_alloc2(6'(i), 6'(i), 32'(8 * i + 4));
      #1;
      checks++; if (alloc_ready !== 1'b1)   begin failures++; $display("FAIL full_ready_%0d got=%0d exp=1", i, alloc_ready); end
      checks++; if (alloc_idx_1 !== 4'(2 * i)) begin failures++; $display("FAIL full_idx_%0d got=%0d exp=%0d", i, alloc_idx_1, 2 * i); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      set_alloc1(6'd1, 6'd1, 32'hdead);
      set_alloc2(6'd2, 6'd2, 32'hbeef);
      #1;
      checks++; if (rob_count !== 5'd16)  begin failures++; $display("FAIL full_count got=%0d exp=16", rob_count); end
      checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL full_not_ready got=%0d exp=0", alloc_ready); end
      checks++; if (alloc_idx_1 !== 4'd0) begin failures++; $display("FAIL full_tail_held got=%0d exp=0", alloc_idx_1); end
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (rob_count !== 5'd16 || rob_empty !== 1'b0) begin failures++; $display("FAIL full_final got=%0d/%0d exp=16/0", rob_count, rob_empty); end
  endtask

  task automatic test_wrap();
    int next_pc = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      clear_inputs();
      if (c < 24) set_alloc1(6'(c), 6'(c + 1), 32'(4 * c));
      if (c >= 1 && c <= 24) begin wb_valid_1 = 1; wb_rob_idx_1 = 4'((c - 1) % 16); end
      #1;
      if (c < 24) begin
        checks++; if (alloc_idx_1 !== 4'(c % 16)) begin failures++; $display("FAIL wrap_idx_%0d got=%0d exp=%0d", c, alloc_idx_1, c % 16); end
      end
      checks++; if (rob_count > 5'd16) begin failures++; $display("FAIL wrap_count_%0d got=%0d exp<=16", c, rob_count); end
      if (commit_valid_1) begin
        checks++; if (commit_pc_1 !== 32'(next_pc)) begin failures++; $display("FAIL wrap_pc1 got=%0d exp=%0d", commit_pc_1, next_pc); end
        next_pc += 4;
      end
      if (commit_valid_2) begin
        checks++; if (commit_pc_2 !== 32'(next_pc)) begin failures++; $display("FAIL wrap_pc2 got=%0d exp=%0d", commit_pc_2, next_pc); end
        next_pc += 4;
      end
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (next_pc != 96)       begin failures++; $display("FAIL wrap_total got=%0d exp=96", next_pc); end
    checks++; if (rob_empty !== 1'b1)  begin failures++; $display("FAIL wrap_empty got=%0d exp=1", rob_empty); end
  endtask

  task automatic test_triple_wb();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      set_alloc1(6'(2 * i), 6'(2 * i), 32'h100 + 32'(8 * i));
      set_alloc2(6'(2 * i + 1), 6'(2 * i + 1), 32'h104 + 32'(8 * i));
      tick();
    end
    clear_inputs();
    set_alloc1(6'd6, 6'd6, 32'h118);
    set_alloc2(6'd7, 6'd7, 32'h11c);
    wb_valid_1 = 1; wb_rob_idx_1 = 4'd3;
    wb_valid_2 = 1; wb_rob_idx_2 = 4'd4;
    wb_valid_3 = 1; wb_rob_idx_3 = 4'd5;
    #1;
    checks++; if (alloc_idx_1 !== 4'd6 || alloc_idx_2 !== 4'd7) begin failures++; $display("FAIL tri_idx got=%0d,%0d exp=6,7", alloc_idx_1, alloc_idx_2); end
    tick();
    clear_inputs();
    #1;
    checks++; if (commit_valid_1 !== 1'b0) begin failures++; $display("FAIL tri_head_blocked got=%0d exp=0", commit_valid_1); end
    checks++; if (rob_count !== 5'd8)      begin failures++; $display("FAIL tri_count got=%0d exp=8", rob_count); end
    wb_valid_1 = 1; wb_rob_idx_1 = 4'd0;
    wb_valid_2 = 1; wb_rob_idx_2 = 4'd1;
    wb_valid_3 = 1; wb_rob_idx_3 = 4'd2;
    tick();
    clear_inputs();
    for (int p = 0; p < 3; p++) begin
      #1;
      checks++; if (commit_valid_1 !== 1'b1 || commit_valid_2 !== 1'b1) begin failures++; $display("FAIL tri_cv_%0d got=%0d%0d exp=11", p, commit_valid_1, commit_valid_2); end
      checks++; if (commit_pc_1 !== 32'h100 + 32'(8 * p) || commit_pc_2 !== 32'h104 + 32'(8 * p)) begin failures++; $display("FAIL tri_pc_%0d got=%0h,%0h exp=%0h,%0h", p, commit_pc_1, commit_pc_2, 32'h100 + 8 * p, 32'h104 + 8 * p); end
      tick();
    end
    #1;
    checks++; if (commit_valid_1 !== 1'b0 || rob_count !== 5'd2) begin failures++; $display("FAIL tri_tail got=%0d/%0d exp=0/2", commit_valid_1, rob_count); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      set_alloc1(6'(i), 6'(i), 32'(8 * i));
      set_alloc2(6'(i), 6'(i), 32'(8 * i + 4));
      tick();
    end
    clear_inputs();
    wb_valid_1 = 1; wb_rob_idx_1 = 4'd0;
    wb_valid_2 = 1; wb_rob_idx_2 = 4'd1;
    tick();
    clear_inputs();
    #1;
    checks++; if (commit_valid_2 !== 1'b1) begin failures++; $display("FAIL rmid_pre_cv got=%0d exp=1", commit_valid_2); end
    rst = 1;
    set_alloc1(6'd9, 6'd9, 32'h40);
    tick();
    rst = 0;
    clear_inputs();
    #1;
    checks++; if (rob_count !== 5'd0)      begin failures++; $display("FAIL rmid_count got=%0d exp=0", rob_count); end
    checks++; if (commit_valid_1 !== 1'b0) begin failures++; $display("FAIL rmid_cv got=%0d exp=0", commit_valid_1); end
    checks++; if (alloc_idx_1 !== 4'd0)    begin failures++; $display("FAIL rmid_tail got=%0d exp=0", alloc_idx_1); end
    checks++; if (rob_empty !== 1'b1)      begin failures++; $display("FAIL rmid_empty got=%0d exp=1", rob_empty); end
  endtask

  task automatic test_random();
    int         cand[$];
    int         nc, j;
    logic [5:0]  e_pd1, e_pd2, e_old1, e_old2;
    logic [31:0] e_pc1, e_pc2;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      if ($urandom_range(0, 9) < 6) set_alloc1(6'($urandom), 6'($urandom), $urandom);
      if ($urandom_range(0, 9) < 5) set_alloc2(6'($urandom), 6'($urandom), $urandom);
      cand.delete();
      foreach (rob_q[k]) if (!rob_q[k].done) cand.push_back(rob_q[k].idx);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        j = $urandom_range(0, cand.size() - 1); wb_valid_1 = 1; wb_rob_idx_1 = 4'(cand[j]); cand.delete(j);
      end
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        j = $urandom_range(0, cand.size() - 1); wb_valid_2 = 1; wb_rob_idx_2 = 4'(cand[j]); cand.delete(j);
      end
      if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        j = $urandom_range(0, cand.size() - 1); wb_valid_3 = 1; wb_rob_idx_3 = 4'(cand[j]); cand.delete(j);
      end
      nc = exp_n_commit();
      e_pd1 = (nc >= 1) ? rob_q[0].pd  : 6'd0; e_pd2 = (nc == 2) ? rob_q[1].pd  : 6'd0;
      e_old1 = (nc >= 1) ? rob_q[0].old : 6'd0; e_old2 = (nc == 2) ? rob_q[1].old : 6'd0;
      e_pc1 = (nc >= 1) ? rob_q[0].pc  : 32'd0; e_pc2 = (nc == 2) ? rob_q[1].pc  : 32'd0;
      #1;
      checks++; if (rob_count !== 5'(rob_q.size())) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, rob_count, rob_q.size()); end
      checks++; if (rob_empty !== (rob_q.size() == 0)) begin failures++; $display("FAIL rnd_empty c=%0d got=%0d exp=%0d", c, rob_empty, rob_q.size() == 0); end
      checks++; if (alloc_ready !== (rob_q.size() <= 14)) begin failures++; $display("FAIL rnd_ready c=%0d got=%0d exp=%0d", c, alloc_ready, rob_q.size() <= 14); end
      checks++; if (alloc_idx_1 !== 4'(m_tail)) begin failures++; $display("FAIL rnd_idx1 c=%0d got=%0d exp=%0d", c, alloc_idx_1, m_tail); end
      checks++; if (alloc_idx_2 !== 4'((m_tail + int'(alloc_valid_1)) % 16)) begin failures++; $display("FAIL rnd_idx2 c=%0d got=%0d exp=%0d", c, alloc_idx_2, (m_tail + int'(alloc_valid_1)) % 16); end
      checks++; if (commit_valid_1 !== (nc >= 1) || commit_valid_2 !== (nc == 2)) begin failures++; $display("FAIL rnd_cv c=%0d got=%0d%0d exp=%0d", c, commit_valid_1, commit_valid_2, nc); end
      checks++; if (commit_pd_1 !== e_pd1 || commit_pd_2 !== e_pd2) begin failures++; $display("FAIL rnd_pd c=%0d got=%0d,%0d exp=%0d,%0d", c, commit_pd_1, commit_pd_2, e_pd1, e_pd2); end
      checks++; if (commit_old_pd_1 !== e_old1 || commit_old_pd_2 !== e_old2) begin failures++; $display("FAIL rnd_old c=%0d got=%0d,%0d exp=%0d,%0d", c, commit_old_pd_1, commit_old_pd_2, e_old1, e_old2); end
      checks++; if (commit_pc_1 !== e_pc1 || commit_pc_2 !== e_pc2) begin failures++; $display("FAIL rnd_pc c=%0d got=%0h,%0h exp=%0h,%0h", c, commit_pc_1, commit_pc_2, e_pc1, e_pc2); end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_out_of_order_done();
    test_full();
    test_wrap();
    test_triple_wb();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
